// File: rtl/hdmi_mux_pkg.sv
// Shared types and helpers for the HDMI source selector: FSM state encoding,
// the black pixel constant and a channel slice helper for packed pixel buses.
package hdmi_mux_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } mux_state_e;

    localparam int N_CH_MAX  = 8;
    localparam int RGB_W_MAX = 48;

    localparam logic [RGB_W_MAX-1:0] RGB_BLACK = '0;

    // Returns pixel k of a packed bus whose lanes are rgb_w bits wide;
    // the result is zero above rgb_w so callers can simply truncate.
    function automatic logic [RGB_W_MAX-1:0] ch_slice(
        input logic [N_CH_MAX*RGB_W_MAX-1:0] data,
        input int unsigned                   k,
        input int unsigned                   rgb_w
    );
        logic [RGB_W_MAX-1:0] mask;
        mask = ~({RGB_W_MAX{1'b1}} << rgb_w);
        return RGB_W_MAX'(data >> (k * rgb_w)) & mask;
    endfunction

endpackage

// File: rtl/hdmi_vs_edge.sv
// Vsync assertion-edge detector with a registered history bit and a clear input
// used when the monitored channel changes.
module hdmi_vs_edge
    import hdmi_mux_pkg::*;
#(
    parameter int VS_POL = 1
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    input  logic vs_in,
    output logic vs_start
);

    logic asserted;
    logic seen_d;
    logic seen_q;

    assign asserted = (vs_in == (VS_POL != 0));
    assign vs_start = asserted & ~seen_q;

    // Clearing pretends vsync was already asserted, so a new source that is
    // mid-vsync never looks like it just started a frame.
    always_comb begin
        seen_d = clr ? 1'b1 : asserted;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            seen_q <= 1'b1;
        end else begin
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/hdmi_src_mux.sv
// N-channel HDMI video source selector with frame-boundary switching and blanking.
// Optional colour-keyed overlay from channel OVL_CH when HDMI_MUX_OVERLAY_EN is defined.
module hdmi_src_mux
    import hdmi_mux_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int RGB_W        = 24,
    parameter int SEL_W        = 3,
    parameter int BLANK_FRAMES = 1,
    parameter int VS_POL       = 1
`ifdef HDMI_MUX_OVERLAY_EN
    ,
    parameter int OVL_CH       = 0
`endif
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        i_vs,
    input  logic [N_CH-1:0]        i_hs,
    input  logic [N_CH-1:0]        i_de,
    input  logic [N_CH*RGB_W-1:0]  i_data,
    input  logic [SEL_W-1:0]       sel,
`ifdef HDMI_MUX_OVERLAY_EN
    input  logic                   ovl_en,
    input  logic [RGB_W-1:0]       ovl_key,
`endif
    output logic                   o_vs,
    output logic                   o_hs,
    output logic                   o_de,
    output logic [RGB_W-1:0]       o_data,
    output logic [SEL_W-1:0]       o_active_ch,
    output logic                   o_switching
);

    localparam int                CH_PAD  = 2 ** SEL_W;
    localparam logic [SEL_W:0]    N_CH_L  = (SEL_W + 1)'(N_CH);
    localparam logic [3:0]        BLANK_N = 4'(BLANK_FRAMES);
    localparam logic              VS_IDLE = (VS_POL == 0);

    mux_state_e               state_d, state_q;
    logic [SEL_W-1:0]         active_ch_d, active_ch_q;
    logic [SEL_W-1:0]         pend_ch_d, pend_ch_q;
    logic [3:0]               blank_cnt_d, blank_cnt_q;
    logic                     pend_req_d, pend_req_q;

    logic                     o_vs_d, o_vs_q;
    logic                     o_hs_d, o_hs_q;
    logic                     o_de_d, o_de_q;
    logic [RGB_W-1:0]         o_data_d, o_data_q;
    logic [SEL_W-1:0]         o_active_ch_d, o_active_ch_q;
    logic                     o_switching_d, o_switching_q;

    logic [CH_PAD-1:0]                vs_ext, hs_ext, de_ext;
    logic [N_CH_MAX*RGB_W_MAX-1:0]    data_ext;
    logic                             cur_vs, cur_hs, cur_de;
    logic [RGB_W-1:0]                 cur_pix;
    logic                             sel_ok;
    logic                             vs_start;
    logic                             edge_clr;

    // Inputs are padded to the full select range so any sel value indexes safely.
    always_comb begin
        vs_ext   = '0;
        hs_ext   = '0;
        de_ext   = '0;
        data_ext = '0;
        vs_ext[N_CH-1:0]         = i_vs;
        hs_ext[N_CH-1:0]         = i_hs;
        de_ext[N_CH-1:0]         = i_de;
        data_ext[N_CH*RGB_W-1:0] = i_data;
    end

    assign cur_vs  = vs_ext[active_ch_q];
    assign cur_hs  = hs_ext[active_ch_q];
    assign cur_de  = de_ext[active_ch_q];
    assign cur_pix = RGB_W'(ch_slice(data_ext, 32'(active_ch_q), RGB_W));
    assign sel_ok  = ({1'b0, sel} < N_CH_L);

    hdmi_vs_edge #(
        .VS_POL (VS_POL)
    ) u_vs_edge (
        .pclk     (pclk),
        .rst      (rst),
        .clr      (edge_clr),
        .vs_in    (cur_vs),
        .vs_start (vs_start)
    );

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        pend_ch_d   = pend_ch_q;
        blank_cnt_d = blank_cnt_q;
        pend_req_d  = pend_req_q;
        edge_clr    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (sel_ok && (sel != active_ch_q)) begin
                    pend_ch_d = sel;
                    state_d   = PEND;
                end
            end
            PEND: begin
                // The boundary wins over a same-cycle sel change: the switch uses
                // the request registered before this edge.
                if (vs_start) begin
                    active_ch_d = pend_ch_q;
                    edge_clr    = 1'b1;
                    blank_cnt_d = '0;
                    pend_req_d  = 1'b0;
                    state_d     = (BLANK_FRAMES == 0) ? RUN : BLANK;
                end else if (sel_ok) begin
                    if (sel == active_ch_q) begin
                        state_d = RUN;
                    end else begin
                        pend_ch_d = sel;
                    end
                end
            end
            BLANK: begin
                if (sel_ok) begin
                    if (sel == active_ch_q) begin
                        pend_req_d = 1'b0;
                    end else begin
                        pend_ch_d  = sel;
                        pend_req_d = 1'b1;
                    end
                end
                if (vs_start) begin
                    if ((blank_cnt_q + 4'd1) == BLANK_N) begin
                        blank_cnt_d = '0;
                        state_d     = pend_req_d ? PEND : RUN;
                        pend_req_d  = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output stage registers what the current state selects, so status flags
    // line up with the pixel they describe.
    always_comb begin
        o_vs_d        = cur_vs;
        o_hs_d        = cur_hs;
        o_de_d        = cur_de;
        o_data_d      = (state_q == BLANK) ? RGB_W'(RGB_BLACK) : cur_pix;
        o_active_ch_d = active_ch_q;
        o_switching_d = (state_q != RUN);
`ifdef HDMI_MUX_OVERLAY_EN
        if ((state_q == RUN) && ovl_en && de_ext[OVL_CH]
            && (RGB_W'(ch_slice(data_ext, OVL_CH, RGB_W)) != ovl_key)
            && (active_ch_q != SEL_W'(OVL_CH))) begin
            o_data_d = RGB_W'(ch_slice(data_ext, OVL_CH, RGB_W));
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= RUN;
            active_ch_q   <= '0;
            pend_ch_q     <= '0;
            blank_cnt_q   <= '0;
            pend_req_q    <= 1'b0;
            o_vs_q        <= VS_IDLE;
            o_hs_q        <= 1'b0;
            o_de_q        <= 1'b0;
            o_data_q      <= '0;
            o_active_ch_q <= '0;
            o_switching_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_ch_q   <= active_ch_d;
            pend_ch_q     <= pend_ch_d;
            blank_cnt_q   <= blank_cnt_d;
            pend_req_q    <= pend_req_d;
            o_vs_q        <= o_vs_d;
            o_hs_q        <= o_hs_d;
            o_de_q        <= o_de_d;
            o_data_q      <= o_data_d;
            o_active_ch_q <= o_active_ch_d;
            o_switching_q <= o_switching_d;
        end
    end

    assign o_vs        = o_vs_q;
    assign o_hs        = o_hs_q;
    assign o_de        = o_de_q;
    assign o_data      = o_data_q;
    assign o_active_ch = o_active_ch_q;
    assign o_switching = o_switching_q;

endmodule
